// File: rtl/rob_wb_arbiter.sv
// rob_wb_arbiter: funnels completions from NUM_REQ execution units into the
// ROB's single registered mark port. Each unit owns a BUF_DEPTH FIFO; a
// round-robin arbiter pops at most one FIFO head per cycle.
// Optional feature macro: WB_ARB_PERF_EN adds per-unit stall counters
// (perf_stall_cnt), saturating at 16'hFFFF and cleared by reset only.

// Per-unit completion FIFO. Pointers carry an extra wrap bit so that
// full/empty decode directly from the pointer pair.
module rob_wb_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  output logic          empty_o,
  output logic          full_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = $clog2(DEPTH) + 1;

  logic [PW-1:0] wptr_q, rptr_q;
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] waddr, raddr;

  generate
    if (DEPTH > 1) begin : g_addr
      assign waddr = wptr_q[AW-1:0];
      assign raddr = rptr_q[AW-1:0];
    end else begin : g_addr1
      assign waddr = '0;
      assign raddr = '0;
    end
  endgenerate

  assign empty_o = (wptr_q == rptr_q);
  // Full when pointers differ only in the wrap bit (DEPTH is a power of 2).
  assign full_o  = ((wptr_q ^ rptr_q) == PW'(DEPTH));
  assign rdata_o = mem_q[raddr];

  // Pointer update; flush empties the FIFO and wins over push/pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + PW'(1);
      if (pop_i)  rptr_q <= rptr_q + PW'(1);
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[waddr] <= wdata_i;
  end
endmodule

module rob_wb_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ROB_SIZE  = 32,
  parameter int BUF_DEPTH = 2,
  localparam int IDX_BITS = $clog2(ROB_SIZE),
  localparam int GID_BITS = $clog2(NUM_REQ)
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ-1:0][IDX_BITS-1:0]   req_rob_idx,
  input  logic [NUM_REQ-1:0]                 req_exception,
  input  logic                               flush_en,
  output logic                               mark_ready_en,
  output logic [IDX_BITS-1:0]                mark_ready_idx,
  output logic                               mark_ready_val,
  output logic                               mark_exception,
  output logic [GID_BITS-1:0]                grant_id,
  output logic                               busy
`ifdef WB_ARB_PERF_EN
  ,output logic [NUM_REQ-1:0][15:0]          perf_stall_cnt
`endif
);
  typedef struct packed {
    logic                exc;
    logic [IDX_BITS-1:0] idx;
  } ent_t;
  localparam int EW = $bits(ent_t);

  logic [NUM_REQ-1:0]         empty_w, full_w, push_w, pop_w;
  logic [NUM_REQ-1:0][EW-1:0] head_w;
  logic                       gnt_vld;
  logic [GID_BITS-1:0]        gnt_id, cand;
  ent_t                       gnt_ent;

  logic                en_q, exc_q;
  logic [IDX_BITS-1:0] idx_q;
  logic [GID_BITS-1:0] gid_q, rr_q;

  // Ready depends on current occupancy only, so a full FIFO never accepts
  // even when it is being popped in the same edge.
  assign req_ready = ~full_w & {NUM_REQ{~flush_en}};
  assign push_w    = req_valid & req_ready;
  assign busy      = ~&empty_w;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign pop_w[gi] = gnt_vld && (gnt_id == GID_BITS'(gi)) && !flush_en;
      rob_wb_fifo #(.DW(EW), .DEPTH(BUF_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush_i (flush_en),
        .push_i  (push_w[gi]),
        .pop_i   (pop_w[gi]),
        .wdata_i ({req_exception[gi], req_rob_idx[gi]}),
        .rdata_o (head_w[gi]),
        .empty_o (empty_w[gi]),
        .full_o  (full_w[gi])
      );
    end
  endgenerate

  // Round-robin scan from rr_q; walking backwards lets the nearest hit win.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = GID_BITS'((int'(rr_q) + k) % NUM_REQ);
      if (!empty_w[cand]) begin
        gnt_vld = 1'b1;
        gnt_id  = cand;
      end
    end
  end

  assign gnt_ent = ent_t'(head_w[gnt_id]);

  // Registered mark port and round-robin pointer; flush overrides a grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q  <= 1'b0;
      exc_q <= 1'b0;
      idx_q <= '0;
      gid_q <= '0;
      rr_q  <= '0;
    end else if (flush_en) begin
      en_q <= 1'b0;
      rr_q <= '0;
    end else if (gnt_vld) begin
      en_q  <= 1'b1;
      exc_q <= gnt_ent.exc;
      idx_q <= gnt_ent.idx;
      gid_q <= gnt_id;
      rr_q  <= GID_BITS'((int'(gnt_id) + 1) % NUM_REQ);
    end else begin
      en_q <= 1'b0;
    end
  end

  assign mark_ready_en  = en_q;
  assign mark_ready_val = en_q;
  assign mark_ready_idx = idx_q;
  assign mark_exception = exc_q;
  assign grant_id       = gid_q;

`ifdef WB_ARB_PERF_EN
  logic [NUM_REQ-1:0][15:0] cnt_q;

  // Saturating stall counters; flush deliberately does not clear them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (req_valid[i] && !req_ready[i] && cnt_q[i] != 16'hFFFF)
          cnt_q[i] <= cnt_q[i] + 16'd1;
    end
  end

  assign perf_stall_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Bench for rob_wb_arbiter: fixed vector table, hand-written corner
// sequences and randomized traffic, all checked against a queue-level model.
module tb_rob_wb_arbiter;
  localparam int N  = 4;
  localparam int D  = 2;
  localparam int IW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset_n;
  logic [N-1:0]          req_valid, req_ready, req_exception;
  logic [N-1:0][IW-1:0]  req_rob_idx;
  logic                  flush_en;
  logic                  mark_ready_en, mark_ready_val, mark_exception, busy;
  logic [IW-1:0]         mark_ready_idx;
  logic [1:0]            grant_id;
`ifdef WB_ARB_PERF_EN
  logic [N-1:0][15:0]    perf_stall_cnt;
`endif

  rob_wb_arbiter #(.NUM_REQ(N), .ROB_SIZE(32), .BUF_DEPTH(D)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_rob_idx    (req_rob_idx),
    .req_exception  (req_exception),
    .flush_en       (flush_en),
    .mark_ready_en  (mark_ready_en),
    .mark_ready_idx (mark_ready_idx),
    .mark_ready_val (mark_ready_val),
    .mark_exception (mark_exception),
    .grant_id       (grant_id),
    .busy           (busy)
`ifdef WB_ARB_PERF_EN
    ,.perf_stall_cnt (perf_stall_cnt)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model: one queue of {exc, idx} per unit plus the rr pointer.
  logic [IW:0]   mq [N][$];
  int            m_rr, m_gid;
  bit            m_en, m_exc;
  logic [IW-1:0] m_idx;
  logic [N-1:0]  acc;
  logic [IW-1:0] log_q [$];

  task automatic model_reset();
    for (int i = 0; i < N; i++) mq[i].delete();
    m_rr = 0; m_en = 0; m_exc = 0; m_idx = '0; m_gid = 0;
  endtask

  // One clock: check ready/busy before the edge, advance the model at the
  // edge, then check the mark port. Entered ~1 time unit after a rising edge.
  task automatic cyc(string tag);
    logic [N-1:0] rdy;
    bit  found, any;
    int  w, j;
    #2;
    any = 0;
    for (int i = 0; i < N; i++) begin
      rdy[i] = (mq[i].size() < D) && !flush_en;
      if (mq[i].size() > 0) any = 1;
    end
    chk({tag, " ready"}, req_ready, rdy);
    chk({tag, " busy"}, busy, any);
    acc = req_valid & rdy;
    @(posedge clk); #1;
    if (flush_en) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_rr = 0; m_en = 0;
    end else begin
      found = 0; w = 0;
      for (int k = 0; k < N; k++) begin
        j = (m_rr + k) % N;
        if (!found && mq[j].size() > 0) begin found = 1; w = j; end
      end
      if (found) begin
        {m_exc, m_idx} = mq[w].pop_front();
        m_gid = w; m_en = 1; m_rr = (w + 1) % N;
      end else m_en = 0;
      for (int i = 0; i < N; i++)
        if (acc[i]) mq[i].push_back({req_exception[i], req_rob_idx[i]});
    end
    chk({tag, " en"}, mark_ready_en, m_en);
    chk({tag, " val"}, mark_ready_val, m_en);
    chk({tag, " idx"}, mark_ready_idx, m_idx);
    chk({tag, " exc"}, mark_exception, m_exc);
    chk({tag, " gid"}, grant_id, m_gid);
    if (mark_ready_en) log_q.push_back(mark_ready_idx);
  endtask

  task automatic clr_in();
    req_valid = '0; req_rob_idx = '0; req_exception = '0; flush_en = 0;
  endtask

  task automatic do_reset();
    clr_in();
    reset_n = 0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst en", mark_ready_en, 0);
    chk("rst val", mark_ready_val, 0);
    chk("rst idx", mark_ready_idx, 0);
    chk("rst exc", mark_exception, 0);
    chk("rst gid", grant_id, 0);
    chk("rst ready", req_ready, 4'hF);
    chk("rst busy", busy, 0);
    model_reset();
    reset_n = 1;
  endtask

  typedef struct {
    bit           rst;
    logic [3:0]   v;
    logic [19:0]  idx;
    logic [3:0]   exc;
    bit           en;
    logic [4:0]   midx;
    bit           mexc;
    logic [1:0]   gid;
    bit           busy;
  } vec_t;

  function automatic vec_t mk(bit rst, logic [3:0] v, logic [19:0] idx, logic [3:0] exc,
                              bit en, logic [4:0] mi, bit me, logic [1:0] g, bit b);
    vec_t r;
    r.rst = rst; r.v = v; r.idx = idx; r.exc = exc;
    r.en = en; r.midx = mi; r.mexc = me; r.gid = g; r.busy = b;
    return r;
  endfunction

  vec_t vt [12];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int c0, c1, bad;
    bit saw_stall;
    clr_in();
    reset_n = 0;
    model_reset();

    // Single completion, then all four units at once (idx {u3,u2,u1,u0}).
    vt[0]  = mk(1, 4'b0100, {5'd0, 5'd5, 5'd0, 5'd0}, 4'b0000, 0, 5'd0, 0, 2'd0, 1);
    vt[1]  = mk(0, 4'b0000, 20'd0,                    4'b0000, 1, 5'd5, 0, 2'd2, 0);
    vt[2]  = mk(0, 4'b0000, 20'd0,                    4'b0000, 0, 5'd5, 0, 2'd2, 0);
    vt[3]  = mk(1, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b1000, 0, 5'd0, 0, 2'd0, 1);
    vt[4]  = mk(0, 4'b0000, 20'd0,                    4'b0000, 1, 5'd1, 0, 2'd0, 1);
    vt[5]  = mk(0, 4'b0000, 20'd0,                    4'b0000, 1, 5'd2, 0, 2'd1, 1);
    vt[6]  = mk(0, 4'b0000, 20'd0,                    4'b0000, 1, 5'd3, 0, 2'd2, 1);
    vt[7]  = mk(0, 4'b0000, 20'd0,                    4'b0000, 1, 5'd4, 1, 2'd3, 0);
    vt[8]  = mk(0, 4'b0000, 20'd0,                    4'b0000, 0, 5'd4, 1, 2'd3, 0);
    vt[9]  = mk(0, 4'b1001, {5'd7, 5'd0, 5'd0, 5'd6}, 4'b0000, 0, 5'd4, 1, 2'd3, 1);
    vt[10] = mk(0, 4'b0000, 20'd0,                    4'b0000, 1, 5'd6, 0, 2'd0, 1);
    vt[11] = mk(0, 4'b0000, 20'd0,                    4'b0000, 1, 5'd7, 0, 2'd3, 0);

    for (int t = 0; t < 12; t++) begin
      if (vt[t].rst) do_reset();
      req_valid = vt[t].v; req_rob_idx = vt[t].idx; req_exception = vt[t].exc;
      cyc("tbl");
      chk($sformatf("vec%0d en", t), mark_ready_en, vt[t].en);
      chk($sformatf("vec%0d idx", t), mark_ready_idx, vt[t].midx);
      chk($sformatf("vec%0d exc", t), mark_exception, vt[t].mexc);
      chk($sformatf("vec%0d gid", t), grant_id, vt[t].gid);
      chk($sformatf("vec%0d busy", t), busy, vt[t].busy);
    end

    // Contention: units 0 and 1 push 6 each, holding valid until accepted.
    do_reset();
    log_q.delete();
    c0 = 0; c1 = 0; saw_stall = 0;
    for (int t = 0; t < 60 && log_q.size() < 12; t++) begin
      req_valid[0] = (c0 < 6); req_rob_idx[0] = IW'(10 + c0);
      req_valid[1] = (c1 < 6); req_rob_idx[1] = IW'(20 + c1);
      #1;
      if (req_valid[0] && !req_ready[0]) saw_stall = 1;
      cyc("cont");
      if (acc[0]) c0++;
      if (acc[1]) c1++;
    end
    clr_in();
    chk("cont stall seen", saw_stall, 1);
    chk("cont mark count", log_q.size(), 12);
    for (int k = 0; k < 12 && k < log_q.size(); k++)
      chk($sformatf("cont order%0d", k), log_q[k], (k % 2 == 0) ? 10 + k / 2 : 20 + k / 2);

    // Flush with three buffered entries and a concurrent push from unit 2.
    do_reset();
    log_q.delete();
    req_valid = 4'b0001; req_rob_idx[0] = 5'd1;
    cyc("fl");
    req_valid = 4'b1011; req_rob_idx[0] = 5'd11; req_rob_idx[1] = 5'd12; req_rob_idx[3] = 5'd13;
    cyc("fl");
    clr_in();
    req_valid = 4'b0100; req_rob_idx[2] = 5'd7; flush_en = 1;
    cyc("fl");
    chk("flush en", mark_ready_en, 0);
    chk("flush busy", busy, 0);
    clr_in();
    repeat (4) cyc("fl idle");
    bad = 0;
    foreach (log_q[k]) if (log_q[k] inside {5'd7, 5'd11, 5'd12, 5'd13}) bad++;
    chk("flush stale marks", bad, 0);
    req_valid = 4'b1001; req_rob_idx[0] = 5'd9; req_rob_idx[3] = 5'd8;
    cyc("fl");
    clr_in();
    cyc("fl");
    chk("flush next gid", grant_id, 0);
    chk("flush next idx", mark_ready_idx, 9);
    cyc("fl");

    // Async reset between edges while entries are in flight.
    do_reset();
    req_valid = 4'b0011; req_rob_idx[0] = 5'd4; req_rob_idx[1] = 5'd6;
    cyc("ar");
    clr_in();
    cyc("ar");
    chk("ar pre en", mark_ready_en, 1);
    #2 reset_n = 0;
    #1;
    chk("ar en", mark_ready_en, 0);
    chk("ar busy", busy, 0);
    model_reset();
    #1 reset_n = 1;
    log_q.delete();
    repeat (4) cyc("ar idle");
    chk("ar stale marks", log_q.size(), 0);

    // Randomized traffic with held requests and occasional flushes.
    do_reset();
    acc = '0;
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || acc[i]) begin
          req_valid[i]     = ($urandom_range(0, 99) < 55);
          req_rob_idx[i]   = IW'($urandom_range(0, 31));
          req_exception[i] = ($urandom_range(0, 9) == 0);
        end
      end
      flush_en = ($urandom_range(0, 99) < 3);
      cyc("rnd");
    end
    clr_in();
    repeat (6) cyc("rnd drain");

`ifdef WB_ARB_PERF_EN
    // Hold unit 3 blocked (flush keeps ready low) long enough to saturate.
    do_reset();
    chk("perf rst", perf_stall_cnt, 64'd0);
    req_valid = 4'b1000; flush_en = 1;
    repeat (70000) @(posedge clk);
    #1;
    chk("perf sat3", perf_stall_cnt[3], 16'hFFFF);
    chk("perf other", {perf_stall_cnt[2], perf_stall_cnt[1], perf_stall_cnt[0]}, 48'd0);
    req_valid = '0;
    @(posedge clk); #1;
    chk("perf flush keep", perf_stall_cnt[3], 16'hFFFF);
    do_reset();
    chk("perf clr", perf_stall_cnt, 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
